blood_bar_anim: RTL and testbench

Parametrised HUD health-bar renderer, the successor to the fixed 5-segment blood bar. It draws 1..MAX_ROWS rows of segments from a sprite ROM, with a row count chosen at run time (normal play 1, godmode 3). Damage leaves a "ghost" segment run that holds, then drains toward the true value. Low health makes the full segments blink. The block sits beside the other HUD object blocks and feeds `is_obj` and `Obj_address` to the palette/ROM mux.

---
 rtl/blood_bar_anim_if.sv | 36 +++
 rtl/blood_bar_anim.sv | 205 ++++++++++++++++++++
 tb/tb_blood_bar_anim.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/blood_bar_anim_if.sv
// Interface bundle for the HUD health-bar renderer.
// The master side (frame/game logic and pixel scanner) drives the frame tick,
// health, row request and current pixel. The slave side (blood_bar_anim)
// returns the pixel-inside-bar flag, the sprite ROM address and two status bits.
//   Frame_Tick    : one-Clk pulse per frame
//   Player_Blood  : current health
//   Rows_Req      : requested row count (0 is treated as 1)
//   PixelX/PixelY : current draw pixel
//   is_obj        : pixel lies inside the bar (registered)
//   Obj_address   : sprite ROM address (registered)
//   Drain_Busy    : ghost run is holding or draining
//   Blink_Active  : low-health blink phase is on
interface blood_bar_anim_if #(
  parameter int BLOOD_W = 10,
  parameter int ADDR_W  = 10
);
  logic               Frame_Tick;
  logic [BLOOD_W-1:0] Player_Blood;
  logic [1:0]         Rows_Req;
  logic [8:0]         PixelX;
  logic [8:0]         PixelY;
  logic               is_obj;
  logic [ADDR_W-1:0]  Obj_address;
  logic               Drain_Busy;
  logic               Blink_Active;

  modport master (
    output Frame_Tick, Player_Blood, Rows_Req, PixelX, PixelY,
    input  is_obj, Obj_address, Drain_Busy, Blink_Active
  );

  modport slave (
    input  Frame_Tick, Player_Blood, Rows_Req, PixelX, PixelY,
    output is_obj, Obj_address, Drain_Busy, Blink_Active
  );
endinterface

// File: rtl/blood_bar_anim.sv
// HUD health-bar renderer: 1..MAX_ROWS rows of SEGS_PER_ROW segments drawn
// from a 4-sprite bank (full, empty, ghost, flash). Health and row count are
// latched once per frame so the bar never tears. Damage leaves a ghost run
// that holds for HOLD_FRAMES frames and then drains one unit every DRAIN_DIV
// frames. Low health blinks the full segments.
// Ports:
//   Clk     : pixel/system clock
//   Reset_n : asynchronous active-low reset
//   bus     : slave side of blood_bar_anim_if (tick, health, rows, pixel in;
//             is_obj, Obj_address, Drain_Busy, Blink_Active out)
module blood_bar_anim #(
  parameter int SEG_W        = 13,
  parameter int SEG_H        = 13,
  parameter int SEGS_PER_ROW = 5,
  parameter int MAX_ROWS     = 3,
  parameter int HP_PER_SEG   = 10,
  parameter int X0           = 5,
  parameter int Y0           = 16,
  parameter int HOLD_FRAMES  = 30,
  parameter int DRAIN_DIV    = 2,
  parameter int LOW_THRESH   = 20,
  parameter int BLINK_FRAMES = 8,
  parameter int BLOOD_W      = 10,
  parameter int ADDR_W       = 10
) (
  input  logic            Clk,
  input  logic            Reset_n,
  blood_bar_anim_if.slave bus
);

  localparam int ROW_PIX = SEGS_PER_ROW * SEG_W;
  localparam int SPR_SZ  = SEG_W * SEG_H;
  localparam int HOLD_W  = $clog2(HOLD_FRAMES + 1);
  localparam int DIV_W   = $clog2(DRAIN_DIV + 1);
  localparam int BLINK_W = $clog2(BLINK_FRAMES + 1);
  localparam logic [BLOOD_W-1:0] LOW_T = BLOOD_W'(LOW_THRESH);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_HOLD  = 2'd1,
    S_DRAIN = 2'd2
  } ghost_state_e;

  ghost_state_e       state_q, state_d;
  logic [1:0]         rows_q, rows_d;
  logic [BLOOD_W-1:0] lat_q, lat_d;
  logic [BLOOD_W-1:0] ghost_q, ghost_d;
  logic [HOLD_W-1:0]  hold_q, hold_d;
  logic [DIV_W-1:0]   div_q, div_d;
  logic [BLINK_W-1:0] blink_cnt_q, blink_cnt_d;
  logic               blink_ph_q, blink_ph_d;
  logic               obj_q, obj_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;

  // Values the frame latch would capture on this cycle's tick.
  logic [1:0]         rows_new;
  logic [BLOOD_W-1:0] blood_new;
  int                 cap;
  logic               damage;
  logic               low_new;
  logic               blink_active;

  always_comb begin
    if (bus.Rows_Req == 2'd0)                 rows_new = 2'd1;
    else if (int'(bus.Rows_Req) > MAX_ROWS)   rows_new = 2'(MAX_ROWS);
    else                                      rows_new = bus.Rows_Req;
    cap       = int'(rows_new) * SEGS_PER_ROW * HP_PER_SEG;
    blood_new = (int'(bus.Player_Blood) > cap) ? BLOOD_W'(cap) : bus.Player_Blood;
    // Damage is judged against the health shown during the frame just ended.
    damage    = (blood_new < lat_q);
    low_new   = (blood_new != '0) && (blood_new < LOW_T);
  end

  // Frame latch, ghost FSM next state and blink counter.
  // NOTE: every always_comb output gets a default first so no path can leave
  // it unassigned and infer a latch.
  always_comb begin
    state_d     = state_q;
    rows_d      = rows_q;
    lat_d       = lat_q;
    ghost_d     = ghost_q;
    hold_d      = hold_q;
    div_d       = div_q;
    blink_cnt_d = blink_cnt_q;
    blink_ph_d  = blink_ph_q;

    if (bus.Frame_Tick) begin
      rows_d = rows_new;
      lat_d  = blood_new;

      if (blood_new >= ghost_q) begin
        // Healing at or past the ghost collapses it onto the true value.
        ghost_d = blood_new;
        state_d = S_IDLE;
        hold_d  = '0;
        div_d   = '0;
      end else begin
        unique case (state_q)
          S_IDLE: begin
            if (damage) begin
              ghost_d = lat_q;
              hold_d  = '0;
              state_d = S_HOLD;
            end else begin
              ghost_d = blood_new;
            end
          end
          S_HOLD: begin
            if (damage) begin
              hold_d = '0;
            end else if (hold_q == HOLD_W'(HOLD_FRAMES - 1)) begin
              hold_d  = '0;
              div_d   = '0;
              state_d = S_DRAIN;
            end else begin
              hold_d = hold_q + HOLD_W'(1);
            end
          end
          S_DRAIN: begin
            if (damage) begin
              hold_d  = '0;
              div_d   = '0;
              state_d = S_HOLD;
            end else if (div_q == DIV_W'(DRAIN_DIV - 1)) begin
              // ghost_q > blood_new here, so one step down cannot undershoot.
              div_d   = '0;
              ghost_d = ghost_q - BLOOD_W'(1);
              if (ghost_q - BLOOD_W'(1) == blood_new) state_d = S_IDLE;
            end else begin
              div_d = div_q + DIV_W'(1);
            end
          end
          default: state_d = S_IDLE;
        endcase
      end

      if (low_new) begin
        if (blink_cnt_q == BLINK_W'(BLINK_FRAMES - 1)) begin
          blink_cnt_d = '0;
          blink_ph_d  = ~blink_ph_q;
        end else begin
          blink_cnt_d = blink_cnt_q + BLINK_W'(1);
        end
      end else begin
        blink_cnt_d = '0;
        blink_ph_d  = 1'b0;
      end
    end
  end

  assign blink_active = blink_ph_q && (lat_q != '0) && (lat_q < LOW_T);

  // Pixel path: uses only registered frame state, so on the tick cycle the
  // pre-update values are rendered.
  int   dx, dy, seg_k, sprite, addr;
  logic in_region;

  always_comb begin
    dx        = int'(bus.PixelX) - X0;
    dy        = int'(bus.PixelY) - Y0;
    in_region = (dx >= 0) && (dx < ROW_PIX) &&
                (dy >= 0) && (dy < int'(rows_q) * SEG_H);
    seg_k     = (dy / SEG_H) * SEGS_PER_ROW + dx / SEG_W;
    if (seg_k < int'(lat_q) / HP_PER_SEG)        sprite = blink_active ? 3 : 0;
    else if (seg_k < int'(ghost_q) / HP_PER_SEG) sprite = 2;
    else                                         sprite = 1;
    addr   = sprite * SPR_SZ + (dy % SEG_H) * SEG_W + dx % SEG_W;
    obj_d  = in_region;
    addr_d = in_region ? ADDR_W'(addr) : '0;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q     <= S_IDLE;
      rows_q      <= 2'd1;
      lat_q       <= '0;
      ghost_q     <= '0;
      hold_q      <= '0;
      div_q       <= '0;
      blink_cnt_q <= '0;
      blink_ph_q  <= 1'b0;
      obj_q       <= 1'b0;
      addr_q      <= '0;
    end else begin
      state_q     <= state_d;
      rows_q      <= rows_d;
      lat_q       <= lat_d;
      ghost_q     <= ghost_d;
      hold_q      <= hold_d;
      div_q       <= div_d;
      blink_cnt_q <= blink_cnt_d;
      blink_ph_q  <= blink_ph_d;
      obj_q       <= obj_d;
      addr_q      <= addr_d;
    end
  end

  assign bus.is_obj       = obj_q;
  assign bus.Obj_address  = addr_q;
  assign bus.Drain_Busy   = (state_q != S_IDLE);
  assign bus.Blink_Active = blink_active;

endmodule

// File: tb/tb_blood_bar_anim.sv
// Self-checking bench for blood_bar_anim. A frame-level model (health, ghost
// level, frames left in hold, frames since low health) predicts every output
// on every cycle; directed literal expectations pin the model at key points.
module tb_blood_bar_anim;

  logic Clk = 1'b0;
  logic Reset_n = 1'b0;
  always #5 Clk = ~Clk;

  blood_bar_anim_if #(.BLOOD_W(10), .ADDR_W(10)) bus ();

  blood_bar_anim dut (
    .Clk     (Clk),
    .Reset_n (Reset_n),
    .bus     (bus)
  );

  int total = 0;
  int bad   = 0;

  // Model state, in frame-level terms.
  int m_rows, m_lat, m_ghost, m_hold_left, m_drain_ph, m_low_n;

  // Literal expectations posted by the stimulus process.
  bit    lit_pix   = 1'b0;
  bit    lit_flags = 1'b0;
  int    lit_obj, lit_addr, lit_busy, lit_blink;
  string lit_name  = "";

  task automatic check(input string name, input logic [31:0] act, input int exp);
    total++;
    if (act !== 32'(exp)) begin
      bad++;
      $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
    end
  endtask

  function automatic int m_blink_on();
    return ((m_low_n / 8) % 2 == 1) && (m_lat > 0) && (m_lat < 20) ? 1 : 0;
  endfunction

  function automatic void model_reset();
    m_rows = 1; m_lat = 0; m_ghost = 0;
    m_hold_left = 0; m_drain_ph = 0; m_low_n = 0;
  endfunction

  function automatic void pix_expect(input int px, input int py, output int o, output int a);
    int dx, dy, k, spr;
    dx = px - 5;
    dy = py - 16;
    if (dx < 0 || dx >= 65 || dy < 0 || dy >= m_rows * 13) begin
      o = 0; a = 0;
    end else begin
      k = (dy / 13) * 5 + dx / 13;
      if (k < m_lat / 10)        spr = m_blink_on() ? 3 : 0;
      else if (k < m_ghost / 10) spr = 2;
      else                       spr = 1;
      o = 1;
      a = spr * 169 + (dy % 13) * 13 + dx % 13;
    end
  endfunction

  function automatic void model_tick(input int blood, input int rreq);
    int rows, nv;
    rows = (rreq == 0) ? 1 : (rreq > 3 ? 3 : rreq);
    nv   = (blood > rows * 50) ? rows * 50 : blood;
    if (nv >= m_ghost) begin
      m_ghost = nv;
    end else if (nv < m_lat) begin
      m_hold_left = 30;            // damage: ghost stays, hold restarts
    end else if (m_hold_left > 0) begin
      m_hold_left--;
      m_drain_ph = 0;
    end else begin
      m_drain_ph++;
      if (m_drain_ph == 2) begin
        m_ghost--;
        m_drain_ph = 0;
      end
    end
    m_rows = rows;
    m_lat  = nv;
    m_low_n = (nv > 0 && nv < 20) ? m_low_n + 1 : 0;
  endfunction

  // Compare process: predict from the inputs seen at the edge, check 1 ns later.
  always @(posedge Clk) begin
    int eo, ea;
    if (!Reset_n) begin
      model_reset();
      eo = 0; ea = 0;
    end else begin
      pix_expect(int'(bus.PixelX), int'(bus.PixelY), eo, ea);
      if (bus.Frame_Tick) model_tick(int'(bus.Player_Blood), int'(bus.Rows_Req));
    end
    #1;
    check("is_obj", 32'(bus.is_obj), eo);
    check("Obj_address", 32'(bus.Obj_address), ea);
    check("Drain_Busy", 32'(bus.Drain_Busy), (m_ghost > m_lat) ? 1 : 0);
    check("Blink_Active", 32'(bus.Blink_Active), m_blink_on());
    if (lit_pix) begin
      check({lit_name, "/is_obj"}, 32'(bus.is_obj), lit_obj);
      check({lit_name, "/addr"}, 32'(bus.Obj_address), lit_addr);
    end
    if (lit_flags) begin
      check({lit_name, "/busy"}, 32'(bus.Drain_Busy), lit_busy);
      check({lit_name, "/blink"}, 32'(bus.Blink_Active), lit_blink);
    end
  end

  task automatic tick(input int blood);
    @(negedge Clk);
    bus.Player_Blood = 10'(blood);
    bus.Frame_Tick   = 1'b1;
    @(negedge Clk);
    bus.Frame_Tick   = 1'b0;
    bus.Player_Blood = 10'(777);   // between-tick value must be ignored
  endtask

  task automatic ticks(input int n, input int blood);
    for (int i = 0; i < n; i++) begin
      bus.PixelX = 9'(2 + (i * 11) % 75);
      bus.PixelY = 9'(14 + (i * 5) % 45);
      tick(blood);
    end
  endtask

  task automatic lit_px(input string nm, input int x, input int y, input int o, input int a);
    @(negedge Clk);
    bus.PixelX = 9'(x);
    bus.PixelY = 9'(y);
    lit_name = nm; lit_obj = o; lit_addr = a; lit_pix = 1'b1;
    @(negedge Clk);
    lit_pix = 1'b0;
  endtask

  task automatic lit_fl(input string nm, input int b, input int bl);
    @(negedge Clk);
    lit_name = nm; lit_busy = b; lit_blink = bl; lit_flags = 1'b1;
    @(negedge Clk);
    lit_flags = 1'b0;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1);
  end

  initial begin
    bus.Frame_Tick   = 1'b0;
    bus.Player_Blood = '0;
    bus.Rows_Req     = 2'd1;
    bus.PixelX       = 9'd5;
    bus.PixelY       = 9'd16;
    repeat (3) @(negedge Clk);
    lit_pix = 1'b1; lit_obj = 0; lit_addr = 0; lit_name = "reset_state";
    lit_flags = 1'b1; lit_busy = 0; lit_blink = 0;
    @(negedge Clk);
    lit_pix = 1'b0; lit_flags = 1'b0;
    Reset_n = 1'b1;

    // Basic render, one row, 50 units.
    tick(50);
    lit_px("basic_origin", 5, 16, 1, 0);
    lit_px("basic_corner", 69, 28, 1, 168);
    lit_px("basic_right_edge", 70, 16, 0, 0);
    lit_px("basic_above", 5, 15, 0, 0);

    // Ghost hold and full drain 50 -> 30.
    tick(30);
    lit_fl("ghost_start", 1, 0);
    lit_px("ghost_seg3", 44, 16, 1, 338);
    ticks(30, 30);
    lit_px("hold_end_seg4", 57, 16, 1, 338);
    ticks(39, 30);
    lit_fl("drain_almost", 1, 0);
    ticks(1, 30);
    lit_fl("drain_done", 0, 0);
    lit_px("drain_done_seg3", 44, 16, 1, 169);

    // Re-damage during drain at ghost 45, then heal past it.
    tick(50);
    tick(30);
    ticks(30, 30);
    ticks(10, 30);
    lit_px("ghost45_seg4", 57, 16, 1, 169);
    lit_px("ghost45_seg3", 44, 16, 1, 338);
    tick(20);
    lit_fl("redamage", 1, 0);
    lit_px("redamage_seg3", 44, 16, 1, 338);
    ticks(29, 20);
    lit_px("rehold_seg3", 44, 16, 1, 338);
    tick(60);
    lit_fl("heal", 0, 0);
    lit_px("heal_seg4", 57, 16, 1, 0);

    // Low-health blink at 15.
    tick(15);
    ticks(6, 15);
    lit_fl("blink_n7", 1, 0);
    lit_px("blink_off_px", 5, 16, 1, 0);
    tick(15);
    lit_fl("blink_n8", 1, 1);
    lit_px("blink_on_px", 5, 16, 1, 507);
    ticks(8, 15);
    lit_px("blink_n16_px", 5, 16, 1, 0);
    ticks(8, 15);
    lit_px("blink_n24_px", 5, 16, 1, 507);
    tick(0);
    lit_fl("blink_zero", 1, 0);

    // Multi-row and clamps.
    bus.Rows_Req = 2'd3;
    tick(120);
    lit_px("rows3_seg10", 5, 42, 1, 0);
    lit_px("rows3_seg12", 31, 42, 1, 169);
    lit_px("rows3_below", 5, 55, 0, 0);
    tick(200);
    lit_px("clamp150_seg14", 58, 43, 1, 14);
    bus.Rows_Req = 2'd0;
    tick(200);
    lit_px("rows0_row1", 5, 29, 0, 0);
    lit_px("rows0_seg4", 58, 17, 1, 14);

    // Reset while draining.
    ticks(33, 50);
    lit_fl("pre_reset_drain", 1, 0);
    @(negedge Clk);
    bus.PixelX = 9'd5; bus.PixelY = 9'd16;
    Reset_n = 1'b0;
    lit_name = "reset_mid_drain";
    lit_pix = 1'b1; lit_obj = 0; lit_addr = 0;
    lit_flags = 1'b1; lit_busy = 0; lit_blink = 0;
    @(negedge Clk);
    lit_pix = 1'b0; lit_flags = 1'b0;
    Reset_n = 1'b1;
    tick(50);
    lit_fl("after_reset", 0, 0);
    lit_px("after_reset_seg3", 44, 16, 1, 0);

    repeat (3) @(negedge Clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
